alu_seq_n: RTL and testbench

Parametrised, registered successor to the 16-bit combinational ALU. It keeps the same opcode map and 6-bit status word, and generalises data width. Shift and rotate operations take a multi-bit count from B and execute iteratively, one bit per cycle. The block sits between the register file and the writeback stage, with valid/ready handshakes on both sides.

---
 rtl/alu_pkg.sv | 48 ++++
 rtl/alu_arith_core.sv | 83 ++++++++
 rtl/alu_seq_n.sv | 158 +++++++++++++++
 tb/tb_alu_seq_n.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcode map, status bit positions and FSM state encoding for alu_seq_n.
package alu_pkg;

  localparam int unsigned OPW = 5;
  localparam int unsigned STW = 6;

  localparam logic [OPW-1:0] OP_INC = 5'b00001;
  localparam logic [OPW-1:0] OP_DEC = 5'b00011;
  localparam logic [OPW-1:0] OP_ADD = 5'b00100;
  localparam logic [OPW-1:0] OP_ADC = 5'b00101;
  localparam logic [OPW-1:0] OP_SUB = 5'b00110;
  localparam logic [OPW-1:0] OP_SBB = 5'b00111;
  localparam logic [OPW-1:0] OP_AND = 5'b01000;
  localparam logic [OPW-1:0] OP_OR  = 5'b01001;
  localparam logic [OPW-1:0] OP_XOR = 5'b01010;
  localparam logic [OPW-1:0] OP_NOT = 5'b01011;
  localparam logic [OPW-1:0] OP_SHL = 5'b10000;
  localparam logic [OPW-1:0] OP_SHR = 5'b10001;
  localparam logic [OPW-1:0] OP_SAL = 5'b10010;
  localparam logic [OPW-1:0] OP_SAR = 5'b10011;
  localparam logic [OPW-1:0] OP_ROL = 5'b10100;
  localparam logic [OPW-1:0] OP_ROR = 5'b10101;
  localparam logic [OPW-1:0] OP_RCL = 5'b10110;
  localparam logic [OPW-1:0] OP_RCR = 5'b10111;

  localparam int unsigned ST_C  = 0;
  localparam int unsigned ST_Z  = 1;
  localparam int unsigned ST_S  = 2;
  localparam int unsigned ST_O  = 3;
  localparam int unsigned ST_P  = 4;
  localparam int unsigned ST_AC = 5;

  typedef enum logic [1:0] {IDLE, EXEC, SHIFT, OUT} state_e;

  function automatic logic is_shift(input logic [OPW-1:0] op);
    return op[4:3] == 2'b10;
  endfunction

  // Opcodes whose carry input can come from the feedback flag.
  function automatic logic uses_carry(input logic [OPW-1:0] op);
    return (op == OP_ADC) || (op == OP_SBB) || (op == OP_RCL) || (op == OP_RCR);
  endfunction

  function automatic logic even_par(input logic [7:0] b);
    return ~^b;
  endfunction

endpackage

// File: rtl/alu_arith_core.sv
// Combinational arithmetic/logic datapath and flag generation; shift opcodes
// and unused opcodes yield zero result and zero status.
module alu_arith_core
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [OPW-1:0]   op_i,
  input  logic             cin_i,
  output logic [WIDTH-1:0] result_o,
  output logic [STW-1:0]   status_o
);

  localparam int unsigned XW = WIDTH + 1;

  logic [WIDTH:0]   ax, bx, sum;
  logic [4:0]       nib;
  logic [WIDTH-1:0] r;
  logic             ci, c, o, legal;

  always_comb begin
    ax    = {1'b0, a_i};
    bx    = {1'b0, b_i};
    sum   = '0;
    nib   = '0;
    r     = '0;
    ci    = 1'b0;
    c     = 1'b0;
    o     = 1'b0;
    legal = 1'b1;
    case (op_i)
      OP_INC: begin
        sum = ax + XW'(1);
        nib = {1'b0, a_i[3:0]} + 5'd1;
        r   = sum[WIDTH-1:0];
        o   = ~a_i[WIDTH-1] & r[WIDTH-1];
      end
      OP_DEC: begin
        sum = ax - XW'(1);
        nib = {1'b0, a_i[3:0]} - 5'd1;
        r   = sum[WIDTH-1:0];
        o   = a_i[WIDTH-1] & ~r[WIDTH-1];
      end
      OP_ADD, OP_ADC: begin
        ci  = (op_i == OP_ADC) & cin_i;
        sum = ax + bx + XW'(ci);
        nib = {1'b0, a_i[3:0]} + {1'b0, b_i[3:0]} + 5'(ci);
        r   = sum[WIDTH-1:0];
        c   = sum[WIDTH];
        o   = (a_i[WIDTH-1] == b_i[WIDTH-1]) && (r[WIDTH-1] != a_i[WIDTH-1]);
      end
      OP_SUB, OP_SBB: begin
        ci  = (op_i == OP_SBB) & cin_i;
        sum = ax - bx - XW'(ci);
        nib = {1'b0, a_i[3:0]} - {1'b0, b_i[3:0]} - 5'(ci);
        r   = sum[WIDTH-1:0];
        c   = sum[WIDTH];
        o   = (a_i[WIDTH-1] != b_i[WIDTH-1]) && (r[WIDTH-1] != a_i[WIDTH-1]);
      end
      OP_AND: r = a_i & b_i;
      OP_OR:  r = a_i | b_i;
      OP_XOR: r = a_i ^ b_i;
      OP_NOT: r = ~a_i;
      default: legal = 1'b0;
    endcase
  end

  always_comb begin
    result_o = r;
    status_o = '0;
    if (legal) begin
      status_o[ST_C]  = c;
      status_o[ST_Z]  = (r == '0);
      status_o[ST_S]  = r[WIDTH-1];
      status_o[ST_O]  = o;
      status_o[ST_P]  = even_par(r[7:0]);
      status_o[ST_AC] = nib[4];
    end
  end

endmodule

// File: rtl/alu_seq_n.sv
// Registered, handshaked ALU with iterative one-bit-per-cycle shifts/rotates.
// Optional macro ALU_FLAG_FEEDBACK_EN: ADC/SBB/RCL/RCR take carry from the last result.
module alu_seq_n
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CNTW  = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [OPW-1:0]   F,
  input  logic             Cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Result,
  output logic [STW-1:0]   Status
);

  state_e           state_q;
  logic [WIDTH-1:0] a_q, b_q, result_q;
  logic [OPW-1:0]   op_q;
  logic             c_q, out_valid_q, in_ready_q;
  logic [CNTW-1:0]  cnt_q, cnt_d;
  logic [STW-1:0]   status_q;
  logic [WIDTH-1:0] core_r, shift_d;
  logic [STW-1:0]   core_s;
  logic             shc_d, carry_src;

  function automatic logic [STW-1:0] mk_status(input logic [WIDTH-1:0] r,
                                               input logic c, input logic o);
    logic [STW-1:0] s;
    s        = '0;
    s[ST_C]  = c;
    s[ST_Z]  = (r == '0);
    s[ST_S]  = r[WIDTH-1];
    s[ST_O]  = o;
    s[ST_P]  = even_par(r[7:0]);
    return s;
  endfunction

`ifdef ALU_FLAG_FEEDBACK_EN
  logic cf_q;

  // Carry of the last completed operation, captured at the result handoff.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cf_q <= 1'b0;
    end else if (state_q == OUT && out_ready) begin
      cf_q <= status_q[ST_C];
    end
  end

  assign carry_src = uses_carry(F) ? cf_q : Cin;
`else
  assign carry_src = Cin;
`endif

  // Oversized counts saturate at WIDTH.
  assign cnt_d = (B[CNTW-1:0] > CNTW'(WIDTH)) ? CNTW'(WIDTH) : B[CNTW-1:0];

  alu_arith_core #(.WIDTH(WIDTH)) u_core (
    .a_i      (a_q),
    .b_i      (b_q),
    .op_i     (op_q),
    .cin_i    (c_q),
    .result_o (core_r),
    .status_o (core_s)
  );

  // One shift/rotate step; RCL/RCR treat c_q as the extra rotate bit.
  always_comb begin
    shift_d = a_q;
    shc_d   = c_q;
    case (op_q)
      OP_SHL, OP_SAL: begin shc_d = a_q[WIDTH-1]; shift_d = {a_q[WIDTH-2:0], 1'b0};       end
      OP_SHR:         begin shc_d = a_q[0];       shift_d = {1'b0, a_q[WIDTH-1:1]};       end
      OP_SAR:         begin shc_d = a_q[0];       shift_d = {a_q[WIDTH-1], a_q[WIDTH-1:1]}; end
      OP_ROL:         begin shc_d = a_q[WIDTH-1]; shift_d = {a_q[WIDTH-2:0], a_q[WIDTH-1]}; end
      OP_ROR:         begin shc_d = a_q[0];       shift_d = {a_q[0], a_q[WIDTH-1:1]};     end
      OP_RCL:         begin shc_d = a_q[WIDTH-1]; shift_d = {a_q[WIDTH-2:0], c_q};        end
      OP_RCR:         begin shc_d = a_q[0];       shift_d = {c_q, a_q[WIDTH-1:1]};        end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= '0;
      c_q         <= 1'b0;
      cnt_q       <= '0;
      result_q    <= '0;
      status_q    <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q        <= A;
            b_q        <= B;
            op_q       <= F;
            c_q        <= carry_src;
            in_ready_q <= 1'b0;
            if (!is_shift(F)) begin
              state_q <= EXEC;
            end else if (cnt_d == '0) begin
              result_q    <= A;
              status_q    <= mk_status(A, carry_src, 1'b0);
              out_valid_q <= 1'b1;
              state_q     <= OUT;
            end else begin
              cnt_q   <= cnt_d;
              state_q <= SHIFT;
            end
          end
        end
        EXEC: begin
          result_q    <= core_r;
          status_q    <= core_s;
          out_valid_q <= 1'b1;
          state_q     <= OUT;
        end
        SHIFT: begin
          a_q   <= shift_d;
          c_q   <= shc_d;
          cnt_q <= cnt_q - CNTW'(1);
          if (cnt_q == CNTW'(1)) begin
            result_q    <= shift_d;
            status_q    <= mk_status(shift_d, shc_d, shift_d[WIDTH-1] ^ a_q[WIDTH-1]);
            out_valid_q <= 1'b1;
            state_q     <= OUT;
          end
        end
        OUT: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign Result    = result_q;
  assign Status    = status_q;

endmodule

// File: tb/tb_alu_seq_n.sv
// Directed vector bench for alu_seq_n (WIDTH=16, default build).
module tb_alu_seq_n;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] A = '0;
  logic [15:0] B = '0;
  logic [4:0]  F = '0;
  logic        Cin = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] Result;
  logic [5:0]  Status;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [4:0]  f;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] exp_r;
    logic [5:0]  exp_s;
    int          exp_lat;
  } vec_t;

  vec_t vecs[17];

  alu_seq_n #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .F         (F),
    .Cin       (Cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Result    (Result),
    .Status    (Status)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [4:0] f, input logic [15:0] a, input logic [15:0] b,
                              input logic cin, input logic [15:0] r, input logic [5:0] s,
                              input int lat);
    vec_t v;
    v.f = f; v.a = a; v.b = b; v.cin = cin;
    v.exp_r = r; v.exp_s = s; v.exp_lat = lat;
    return v;
  endfunction

  // Issue one request, count edges from accept to out_valid, then hand off.
  task automatic run_op(input logic [4:0] f, input logic [15:0] a, input logic [15:0] b,
                        input logic cin, output logic [15:0] r, output logic [5:0] s,
                        output int lat);
    int guard;
    guard = 0;
    while (!in_ready && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 50) check("in_ready timeout", 32'(in_ready), 32'd1);
    F = f; A = a; B = b; Cin = cin; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    r = Result;
    s = Status;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    logic [15:0] r;
    logic [5:0]  s;
    int          lat;

    vecs[0]  = mk(5'b00100, 16'h7fff, 16'h0001, 1'b0, 16'h8000, 6'h3c, 2);  // ADD overflow
    vecs[1]  = mk(5'b00111, 16'h00f0, 16'h0002, 1'b1, 16'h00ed, 6'h30, 2);  // SBB
    vecs[2]  = mk(5'b10100, 16'h7521, 16'h0003, 1'b0, 16'ha90b, 6'h05, 4);  // ROL 3
    vecs[3]  = mk(5'b10111, 16'h8f00, 16'h0003, 1'b1, 16'h31e0, 6'h00, 4);  // RCR 3
    vecs[4]  = mk(5'b10111, 16'h8f00, 16'h0000, 1'b1, 16'h8f00, 6'h15, 1);  // RCR count 0
    vecs[5]  = mk(5'b00110, 16'h0005, 16'h0007, 1'b0, 16'hfffe, 6'h25, 2);  // SUB borrow
    vecs[6]  = mk(5'b00001, 16'hffff, 16'h0000, 1'b0, 16'h0000, 6'h32, 2);  // INC wrap
    vecs[7]  = mk(5'b00011, 16'h8000, 16'h0000, 1'b0, 16'h7fff, 6'h38, 2);  // DEC overflow
    vecs[8]  = mk(5'b01010, 16'h00ff, 16'h00ff, 1'b0, 16'h0000, 6'h12, 2);  // XOR zero
    vecs[9]  = mk(5'b01011, 16'h00f0, 16'h0000, 1'b0, 16'hff0f, 6'h14, 2);  // NOT
    vecs[10] = mk(5'b10000, 16'h8001, 16'h0014, 1'b0, 16'h0000, 6'h1b, 17); // SHL clamp
    vecs[11] = mk(5'b10101, 16'h1234, 16'h0010, 1'b0, 16'h1234, 6'h00, 17); // ROR by WIDTH
    vecs[12] = mk(5'b01000, 16'hf0f0, 16'hff00, 1'b0, 16'hf000, 6'h14, 2);  // AND
    vecs[13] = mk(5'b00101, 16'hffff, 16'h0000, 1'b1, 16'h0000, 6'h33, 2);  // ADC carry
    vecs[14] = mk(5'b00000, 16'h1234, 16'h5678, 1'b1, 16'h0000, 6'h00, 2);  // unused opcode
    vecs[15] = mk(5'b10011, 16'h8000, 16'h0004, 1'b0, 16'hf800, 6'h14, 5);  // SAR 4
    vecs[16] = mk(5'b01001, 16'h0a00, 16'h0050, 1'b0, 16'h0a50, 6'h10, 2);  // OR

    #22 rst_n = 1'b1;
    @(posedge clk); #1;
    check("reset Result", 32'(Result), 32'h0);
    check("reset Status", 32'(Status), 32'h0);
    check("reset out_valid", 32'(out_valid), 32'h0);
    check("reset in_ready", 32'(in_ready), 32'h1);

    for (int i = 0; i < 17; i++) begin
      run_op(vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].cin, r, s, lat);
      check($sformatf("vec%0d result", i), 32'(r), 32'(vecs[i].exp_r));
      check($sformatf("vec%0d status", i), 32'(s), 32'(vecs[i].exp_s));
      check($sformatf("vec%0d latency", i), 32'(lat), 32'(vecs[i].exp_lat));
    end

    // Backpressure: result held while a second request waits.
    F = 5'b00100; A = 16'h0001; B = 16'h0002; Cin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    F = 5'b01010; A = 16'h00ff; B = 16'h000f;
    @(posedge clk); #1;
    check("bp out_valid", 32'(out_valid), 32'h1);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      check($sformatf("bp%0d Result", k), 32'(Result), 32'h0003);
      check($sformatf("bp%0d Status", k), 32'(Status), 32'h10);
      check($sformatf("bp%0d in_ready", k), 32'(in_ready), 32'h0);
      check($sformatf("bp%0d out_valid", k), 32'(out_valid), 32'h1);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("handoff in_ready", 32'(in_ready), 32'h1);
    check("handoff out_valid", 32'(out_valid), 32'h0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("second accept in_ready", 32'(in_ready), 32'h0);
    @(posedge clk); #1;
    check("second out_valid", 32'(out_valid), 32'h1);
    check("second Result", 32'(Result), 32'h00f0);
    check("second Status", 32'(Status), 32'h10);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;

    // Asynchronous reset in the middle of a long shift.
    F = 5'b10001; A = 16'hffff; B = 16'd15; Cin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("arst Result", 32'(Result), 32'h0);
    check("arst Status", 32'(Status), 32'h0);
    check("arst out_valid", 32'(out_valid), 32'h0);
    check("arst in_ready", 32'(in_ready), 32'h1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post-reset in_ready", 32'(in_ready), 32'h1);
    repeat (16) @(posedge clk);
    #1;
    check("abandoned shift out_valid", 32'(out_valid), 32'h0);
    run_op(5'b00100, 16'h0f0f, 16'h0101, 1'b0, r, s, lat);
    check("post-reset ADD result", 32'(r), 32'h1010);
    check("post-reset ADD status", 32'(s), 32'h20);
    check("post-reset ADD latency", 32'(lat), 32'd2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
